// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing to slave1/slave2,
// PREADY wait states and timeout abort. All outputs are registered.
module apb_master_arb #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W:0]   req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W:0]   req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY1,
  input  logic              PREADY2,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic              grant, grant_nx;
  logic [7:0]        count, count_nx;
  logic              ack0_nx, ack1_nx, rsp_valid_nx, rsp_id_nx, rsp_err_nx;
  logic [DATA_W-1:0] rsp_rdata_nx;
  logic              psel1_nx, psel2_nx, penable_nx, pwrite_nx;
  logic [ADDR_W-1:0] paddr_nx;
  logic [DATA_W-1:0] pwdata_nx;

  logic              pick, pick_write, sel_ready;
  logic [ADDR_W:0]   pick_addr;
  logic [DATA_W-1:0] pick_wdata, sel_rdata;

  // With both requesting, the one not granted last wins; grant resets to 1 so req0 goes first.
  assign pick       = (req0_valid && req1_valid) ? ~grant : req1_valid;
  assign pick_write = pick ? req1_write : req0_write;
  assign pick_addr  = pick ? req1_addr  : req0_addr;
  assign pick_wdata = pick ? req1_wdata : req0_wdata;
  assign sel_ready  = PSEL2 ? PREADY2 : PREADY1;
  assign sel_rdata  = PSEL2 ? PRDATA2 : PRDATA1;

  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    count_nx     = count;
    ack0_nx      = 1'b0;
    ack1_nx      = 1'b0;
    rsp_valid_nx = 1'b0;
    rsp_id_nx    = 1'b0;
    rsp_err_nx   = 1'b0;
    rsp_rdata_nx = '0;
    psel1_nx     = PSEL1;
    psel2_nx     = PSEL2;
    penable_nx   = PENABLE;
    pwrite_nx    = PWRITE;
    paddr_nx     = PADDR;
    pwdata_nx    = PWDATA;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_nx   = SETUP;
          grant_nx   = pick;
          ack0_nx    = ~pick;
          ack1_nx    = pick;
          pwrite_nx  = pick_write;
          paddr_nx   = pick_addr[ADDR_W-1:0];
          pwdata_nx  = pick_wdata;
          psel1_nx   = ~pick_addr[ADDR_W];
          psel2_nx   = pick_addr[ADDR_W];
          penable_nx = 1'b0;
        end
      end
      SETUP: begin
        state_nx   = ACCESS;
        penable_nx = 1'b1;
        count_nx   = '0;
      end
      ACCESS: begin
        if (sel_ready || count >= COUNT_LAST) begin
          state_nx     = IDLE;
          psel1_nx     = 1'b0;
          psel2_nx     = 1'b0;
          penable_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_id_nx    = grant;
          rsp_err_nx   = ~sel_ready;
          rsp_rdata_nx = (sel_ready && !PWRITE) ? sel_rdata : '0;
        end else if (count != 8'hFF) begin
          count_nx = count + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b1;
      count     <= '0;
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      count     <= count_nx;
      req0_ack  <= ack0_nx;
      req1_ack  <= ack1_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_id    <= rsp_id_nx;
      rsp_err   <= rsp_err_nx;
      rsp_rdata <= rsp_rdata_nx;
      PSEL1     <= psel1_nx;
      PSEL2     <= psel2_nx;
      PENABLE   <= penable_nx;
      PWRITE    <= pwrite_nx;
      PADDR     <= paddr_nx;
      PWDATA    <= pwdata_nx;
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: single transfers from a vector table,
// then round-robin, reset-abort and reset grant-priority sequences.
module tb_apb_master_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_write, req1_valid, req1_write;
  logic [8:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ack, req1_ack;
  logic       rsp_valid, rsp_id, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic       PREADY1, PREADY2;
  logic [7:0] PRDATA1, PRDATA2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  apb_master_arb #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY1(PREADY1), .PREADY2(PREADY2), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
  );

  // waits = ACCESS cycles with PREADY low before it rises (255 = never);
  // lat = clock edges from the grant edge to the rsp_valid edge.
  typedef struct {
    logic       id;
    logic       write;
    logic [8:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_write = 1'b0; req1_write = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
    PREADY1 = 1'b0; PREADY2 = 1'b0; PRDATA1 = '0; PRDATA2 = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Selected slave gets rdy; the unselected one is held ready with junk data to prove it is ignored.
  task automatic set_slaves(input logic slv, input logic rdy, input logic [7:0] data);
    PREADY1 = slv ? 1'b1 : rdy;
    PREADY2 = slv ? rdy : 1'b1;
    PRDATA1 = slv ? 8'hEE : data;
    PRDATA2 = slv ? data : 8'hEE;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    logic slv;
    int lat;
    slv = v.addr[8];
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_write = v.write; req0_addr = v.addr; req0_wdata = v.wdata;
    end else begin
      req1_valid = 1'b1; req1_write = v.write; req1_addr = v.addr; req1_wdata = v.wdata;
    end
    set_slaves(slv, 1'b0, v.prdata);
    tick();
    check_output($sformatf("v%0d_ack", idx), {req1_ack, req0_ack}, v.id ? 2'b10 : 2'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_output($sformatf("v%0d_setup_sel", idx), {PSEL1, PSEL2, PENABLE}, {~slv, slv, 1'b0});
    check_output($sformatf("v%0d_paddr", idx), PADDR, v.addr[7:0]);
    check_output($sformatf("v%0d_pwrite", idx), PWRITE, v.write);
    if (v.write) check_output($sformatf("v%0d_pwdata", idx), PWDATA, v.wdata);
    set_slaves(slv, v.waits == 0, v.prdata);
    tick();
    check_output($sformatf("v%0d_access_sel", idx), {PSEL1, PSEL2, PENABLE}, {~slv, slv, 1'b1});
    lat = 1;
    while (lat < 40) begin
      tick();
      lat++;
      if (rsp_valid) break;
      set_slaves(slv, (lat - 1) >= v.waits, v.prdata);
    end
    check_output($sformatf("v%0d_rsp_seen", idx), rsp_valid, 1'b1);
    check_output($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check_output($sformatf("v%0d_rsp_id", idx), rsp_id, v.id);
    check_output($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
    check_output($sformatf("v%0d_err", idx), rsp_err, v.exp_err);
    check_output($sformatf("v%0d_bus_idle", idx), {PSEL1, PSEL2, PENABLE}, 3'b000);
    set_slaves(slv, 1'b0, 8'h00);
    tick();
  endtask

  initial begin
    int   first_ack, last_rsp, n, quiet_bad;
    logic ids[6];
    logic [7:0] rd[6];

    vecs[0] = '{1'b0, 1'b1, 9'h005, 8'hA5, 0,   8'h00, 8'h00, 1'b0, 2};
    vecs[1] = '{1'b1, 1'b0, 9'h105, 8'h00, 0,   8'h3C, 8'h3C, 1'b0, 2};
    vecs[2] = '{1'b0, 1'b0, 9'h0AA, 8'h00, 3,   8'h77, 8'h77, 1'b0, 5};
    vecs[3] = '{1'b0, 1'b0, 9'h010, 8'h00, 255, 8'h55, 8'h00, 1'b1, 16};
    vecs[4] = '{1'b1, 1'b1, 9'h1FF, 8'h5A, 1,   8'h99, 8'h00, 1'b0, 3};
    vecs[5] = '{1'b1, 1'b0, 9'h0C3, 8'h00, 0,   8'hE1, 8'hE1, 1'b0, 2};

    do_reset();
    check_output("reset_outputs",
                 {req0_ack, req1_ack, rsp_valid, rsp_id, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE},
                 9'd0);
    check_output("reset_data", {rsp_rdata, PADDR, PWDATA}, 24'd0);

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], i);

    // Both requesters always pending: grants alternate starting with req0, 3-cycle period.
    do_reset();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h001;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h102;
    PREADY1 = 1'b1; PREADY2 = 1'b1; PRDATA1 = 8'h11; PRDATA2 = 8'h22;
    first_ack = -1; last_rsp = -1; n = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      if (first_ack < 0 && (req0_ack || req1_ack)) begin
        first_ack = cyc;
        check_output("rr_first_ack", {req1_ack, req0_ack}, 2'b01);
      end
      if (rsp_valid) begin
        ids[n] = rsp_id; rd[n] = rsp_rdata; n++; last_rsp = cyc;
        if (n == 6) break;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_output("rr_count", n, 6);
    if (n == 6) begin
      check_output("rr_ids", {ids[0], ids[1], ids[2], ids[3], ids[4], ids[5]}, 6'b010101);
      check_output("rr_rdata", {rd[0], rd[1], rd[2], rd[3], rd[4], rd[5]}, 48'h112211221122);
      check_output("rr_span", last_rsp - first_ack, 17);
    end
    tick();

    // Reset in ACCESS drops the transfer and restores req0 priority (req0 was granted last).
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h020;
    PREADY1 = 1'b0; PREADY2 = 1'b0;
    tick();
    check_output("abort_ack", req0_ack, 1'b1);
    req0_valid = 1'b0;
    tick(); tick();
    check_output("abort_in_access", {PSEL1, PENABLE}, 2'b11);
    reset = 1'b1;
    tick();
    check_output("abort_outputs",
                 {req0_ack, req1_ack, rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE},
                 8'd0);
    check_output("abort_paddr", PADDR, 8'h00);
    reset = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid || PSEL1 || PENABLE) quiet_bad++;
    end
    check_output("abort_quiet", quiet_bad, 0);
    req0_valid = 1'b1; req0_addr = 9'h030;
    req1_valid = 1'b1; req1_addr = 9'h131;
    tick();
    check_output("post_reset_grant", {req1_ack, req0_ack}, 2'b01);
    check_output("post_reset_sel", {PSEL1, PSEL2}, 2'b10);
    req0_valid = 1'b0; req1_valid = 1'b0;
    PREADY1 = 1'b1;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
